// File: rtl/vga_line_prefetch.sv
// Raster-order pixel prefetch: word reads from frame memory into a small FIFO, one RGB332 pixel out per active cycle.
// Latency: pixel popped in cycle N is on red/green/blue in cycle N+1; underrun flag rises the cycle after an empty pop.
// Backpressure: requests are credit limited (fifo count + outstanding < FIFO_DEPTH) and held stable until memGnt.
module vga_line_prefetch #(
    parameter int H_DISPLAY  = 640,
    parameter int V_DISPLAY  = 480,
    parameter int ADDR_WIDTH = 19,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clkDiv,
    input  logic                  rst,
    input  logic [8:0]            row,
    input  logic [9:0]            column,
    input  logic                  displayActive,
    input  logic                  vSync,
    output logic                  memReq,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic                  memGnt,
    input  logic                  memRdValid,
    input  logic [7:0]            memRdData,
    output logic [2:0]            red,
    output logic [2:0]            green,
    output logic [1:0]            blue,
    output logic                  underrun
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_DISPLAY * V_DISPLAY - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
    localparam logic [PW-1:0]         PTR_ONE   = PW'(1);
    localparam logic [CW:0]           DEPTH_X   = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {FETCH, DONE, FLUSH} state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [PW-1:0]         wr_q, wr_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [7:0]            pix_q, pix_d;
    logic                  unr_q, unr_d;
    logic                  vsync_q;
    logic                  fifo_we;
    logic [7:0]            fifo_mem [FIFO_DEPTH];

    // Timing-controller position is informational only; addressing is self-counted.
    logic unused_pos;
    assign unused_pos = ^{row, column};

    logic granted, ret, pop, empty_pop, push, vsync_fall;

    // Next-state for the fetch FSM, credit counters, FIFO pointers and the pixel register.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        outst_d = outst_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        pix_d   = '0;
        unr_d   = unr_q;
        fifo_we = 1'b0;

        granted    = req_q & memGnt;
        ret        = memRdValid & (outst_q != '0);
        pop        = displayActive & (cnt_q != '0);
        empty_pop  = displayActive & (cnt_q == '0);
        vsync_fall = vsync_q & ~vSync;
        // Returns during FLUSH, and those owed to underrun pixels, never reach the FIFO.
        push       = ret & (state_q != FLUSH) & (drop_q == '0);

        case ({granted, ret})
            2'b10:   outst_d = outst_q + CNT_ONE;
            2'b01:   outst_d = outst_q - CNT_ONE;
            default: outst_d = outst_q;
        endcase

        if (ret && state_q != FLUSH && drop_q != '0) begin
            drop_d = drop_q - CNT_ONE;
        end
        // An empty pop owes one late word; dropping it keeps later pixels aligned.
        if (empty_pop) begin
            unr_d = 1'b1;
            if (drop_d != '1) begin
                drop_d = drop_d + CNT_ONE;
            end
        end

        if (pop) begin
            pix_d = fifo_mem[rd_q];
            rd_d  = rd_q + PTR_ONE;
        end
        if (push) begin
            fifo_we = 1'b1;
            wr_d    = wr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        // The address saturates at the last pixel so it never wraps inside a frame.
        if (granted && addr_q != LAST_ADDR) begin
            addr_d = addr_q + ADDR_ONE;
        end

        case (state_q)
            FETCH: if (granted && addr_q == LAST_ADDR) state_d = DONE;
            DONE:  state_d = DONE;
            FLUSH: begin
                if (outst_q == '0 && !req_q && !vsync_fall) begin
                    state_d = FETCH;
                    addr_d  = '0;
                    cnt_d   = '0;
                    wr_d    = '0;
                    rd_d    = '0;
                    drop_d  = '0;
                end
            end
            default: state_d = FETCH;
        endcase
        if (vsync_fall) begin
            state_d = FLUSH;
        end

        // A request in flight is held until granted, even across a resync.
        if (req_q && !memGnt) begin
            req_d = 1'b1;
        end else begin
            req_d = (state_d == FETCH) && (({1'b0, cnt_d} + {1'b0, outst_d}) < DEPTH_X);
        end
    end

    // State and output registers.
    always_ff @(posedge clkDiv or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            req_q   <= 1'b0;
            addr_q  <= '0;
            outst_q <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            pix_q   <= '0;
            unr_q   <= 1'b0;
            vsync_q <= 1'b1;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            outst_q <= outst_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            pix_q   <= pix_d;
            unr_q   <= unr_d;
            vsync_q <= vSync;
        end
    end

    // Pixel storage; contents need no reset since occupancy is tracked by cnt_q.
    always_ff @(posedge clkDiv) begin
        if (fifo_we) begin
            fifo_mem[wr_q] <= memRdData;
        end
    end

    assign memReq   = req_q;
    assign memAddr  = addr_q;
    assign red      = pix_q[7:5];
    assign green    = pix_q[4:2];
    assign blue     = pix_q[1:0];
    assign underrun = unr_q;

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Directed bench for vga_line_prefetch with a latency-2 in-order memory model.
// A reduced 16x16 frame keeps the end-of-frame DONE behaviour reachable in a short run.
// Memory word returned for an address is address[7:0].
module tb_vga_line_prefetch;
    logic        clkDiv = 1'b0;
    logic        rst;
    logic [8:0]  row;
    logic [9:0]  column;
    logic        displayActive;
    logic        vSync;
    logic        memReq;
    logic [18:0] memAddr;
    logic        memGnt;
    logic        memRdValid;
    logic [7:0]  memRdData;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
    logic        underrun;
    logic [7:0]  pix;

    assign pix = {red, green, blue};

    vga_line_prefetch #(
        .H_DISPLAY (16),
        .V_DISPLAY (16),
        .ADDR_WIDTH(19),
        .FIFO_DEPTH(16)
    ) dut (
        .clkDiv       (clkDiv),
        .rst          (rst),
        .row          (row),
        .column       (column),
        .displayActive(displayActive),
        .vSync        (vSync),
        .memReq       (memReq),
        .memAddr      (memAddr),
        .memGnt       (memGnt),
        .memRdValid   (memRdValid),
        .memRdData    (memRdData),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .underrun     (underrun)
    );

    always #5 clkDiv = ~clkDiv;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          lat = 2;
    bit          gnt_en = 1'b0;
    bit          stall = 1'b0;
    logic [18:0] q_addr[$];
    int          q_due[$];
    int          ngrants = 0;
    logic [18:0] exp_addr = '0;
    logic [18:0] last_gnt = '0;
    int          addr_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive memory-side inputs for the coming posedge, then advance to the next negedge.
    task automatic tick();
        logic [18:0] a;
        memGnt = gnt_en;
        if (memReq && memGnt) begin
            if (memAddr !== exp_addr) addr_err++;
            exp_addr = exp_addr + 19'd1;
            last_gnt = memAddr;
            ngrants++;
            q_addr.push_back(memAddr);
            q_due.push_back(cyc + 1 + lat);
        end
        memRdValid = 1'b0;
        memRdData  = 8'h00;
        if (!stall && q_due.size() > 0 && q_due[0] <= cyc + 1) begin
            a          = q_addr.pop_front();
            memRdValid = 1'b1;
            memRdData  = a[7:0];
            void'(q_due.pop_front());
        end
        @(posedge clkDiv);
        @(negedge clkDiv);
        cyc++;
    endtask

    initial begin
        int n;
        int err;
        rst = 1'b0; row = '0; column = '0; displayActive = 1'b0; vSync = 1'b1;
        memGnt = 1'b0; memRdValid = 1'b0; memRdData = '0;

        // Reset state
        @(negedge clkDiv);
        @(negedge clkDiv);
        check("rst_memReq", 32'(memReq), 32'd0);
        check("rst_memAddr", 32'(memAddr), 32'd0);
        check("rst_pixel", 32'(pix), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);

        // Prefetch with display blanked: exactly 16 grants at 0..15
        rst = 1'b1;
        gnt_en = 1'b1;
        tick();
        check("first_req", 32'(memReq), 32'd1);
        check("first_addr", 32'(memAddr), 32'd0);
        for (int i = 0; i < 39; i++) tick();
        check("prefetch_grants", 32'(ngrants), 32'd16);
        check("prefetch_req_low", 32'(memReq), 32'd0);
        check("prefetch_addr", 32'(memAddr), 32'd16);
        check("prefetch_underrun", 32'(underrun), 32'd0);
        check("blank_pixel", 32'(pix), 32'd0);

        // Stream 20 pixels of line 0
        for (int i = 0; i < 20; i++) begin
            displayActive = 1'b1;
            tick();
            check("stream_pix", 32'(pix), 32'(i));
        end
        displayActive = 1'b0;
        tick();
        check("stream_blank", 32'(pix), 32'd0);
        for (int i = 0; i < 7; i++) tick();
        check("stream_grants", 32'(ngrants), 32'd36);

        // Grant withheld for 5 cycles: request and address hold
        gnt_en = 1'b0;
        displayActive = 1'b1;
        tick();
        check("hold_pop_pix", 32'(pix), 32'd20);
        displayActive = 1'b0;
        err = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (memReq !== 1'b1 || memAddr !== 19'd36) err++;
        end
        check("hold_stable", 32'(err), 32'd0);
        check("hold_addr", 32'(memAddr), 32'd36);
        gnt_en = 1'b1;
        tick();
        check("hold_grant_addr", 32'(memAddr), 32'd37);
        check("hold_grant_req", 32'(memReq), 32'd0);

        // Memory stalled: drain FIFO, then three underrun pixels
        stall = 1'b1;
        for (int i = 21; i < 36; i++) begin
            displayActive = 1'b1;
            tick();
            check("drain_pix", 32'(pix), 32'(i));
        end
        check("pre_underrun", 32'(underrun), 32'd0);
        tick();
        check("underrun_pix0", 32'(pix), 32'd0);
        check("underrun_flag", 32'(underrun), 32'd1);
        tick();
        check("underrun_pix1", 32'(pix), 32'd0);
        tick();
        check("underrun_pix2", 32'(pix), 32'd0);
        displayActive = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        displayActive = 1'b1;
        tick();
        check("realign_pix39", 32'(pix), 32'd39);
        tick();
        check("realign_pix40", 32'(pix), 32'd40);
        displayActive = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Mid-frame resync with one pending request and 4 outstanding
        stall = 1'b1;
        for (int i = 41; i < 46; i++) begin
            displayActive = 1'b1;
            tick();
            check("pre_sync_pix", 32'(pix), 32'(i));
        end
        displayActive = 1'b0;
        gnt_en = 1'b0;
        tick();
        check("sync_pending_req", 32'(memReq), 32'd1);
        vSync = 1'b0;
        tick();
        check("flush_req_held", 32'(memReq), 32'd1);
        gnt_en = 1'b1;
        tick();
        check("flush_req_done", 32'(memReq), 32'd0);
        stall = 1'b0;
        n = 0;
        err = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (memAddr == 19'd0) break;
            if (memReq !== 1'b0) err++;
        end
        check("flush_cycles", 32'(n), 32'd6);
        check("flush_no_req", 32'(err), 32'd0);
        check("flush_refetch_req", 32'(memReq), 32'd1);
        check("addr_seq_pre_flush", 32'(addr_err), 32'd0);

        // Refetched frame starts from pixel 0 with an emptied FIFO
        exp_addr = '0;
        ngrants = 0;
        vSync = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        check("underrun_sticky", 32'(underrun), 32'd1);
        for (int i = 0; i < 3; i++) begin
            displayActive = 1'b1;
            tick();
            check("refetch_pix", 32'(pix), 32'(i));
        end

        // Rest of the frame: DONE after the last address
        err = 0;
        for (int i = 3; i < 256; i++) begin
            tick();
            if (pix !== 8'(i)) err++;
        end
        check("frame_pix_errors", 32'(err), 32'd0);
        displayActive = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("done_req_low", 32'(memReq), 32'd0);
        check("frame_grants", 32'(ngrants), 32'd256);
        check("frame_last_grant", 32'(last_gnt), 32'd255);
        check("done_addr", 32'(memAddr), 32'd255);
        check("frame_addr_seq", 32'(addr_err), 32'd0);

        // Next vSync falling edge restarts from 0
        vSync = 1'b0;
        tick();
        check("done_flush_req", 32'(memReq), 32'd0);
        tick();
        check("restart_addr", 32'(memAddr), 32'd0);
        check("restart_req", 32'(memReq), 32'd1);
        vSync = 1'b1;
        exp_addr = '0;
        ngrants = 0;
        tick();
        check("restart_grant_cnt", 32'(ngrants), 32'd1);
        check("restart_grant_addr", 32'(last_gnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
